sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum output.
- Accepts a programmed number of sum beats over a valid/ready handshake, accumulates them into a wider running total, then presents the result with a sticky overflow flag.
- Sits directly after the adder datapath and is the first clocked stage behind it.

Parameters:
- IN_W, 5, width of each incoming sum beat (matches the adder sum width).
- ACC_W, 12, width of the accumulated total; must be greater than IN_W.
- CNT_W, 8, width of the beat-count field; up to 2^CNT_W-1 beats per run.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; sampled only in IDLE.
- len  input  CNT_W  number of beats in the run; sampled when start is accepted.
- in_valid  input  1  in_sum holds a valid beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_sum  input  IN_W  sum beat, unsigned.
- out_valid  output  1  out_total and out_ovf are valid.
- out_ready  input  1  downstream accepts the result.
- out_total  output  ACC_W  accumulated total, unsigned.
- out_ovf  output  1  sticky flag: the total exceeded 2^ACC_W-1 during the run.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset is asynchronous and active-high. Asserting rst forces:
  - state to IDLE;
  - in_ready, out_valid, out_ovf and busy to 0;
  - out_total and the remaining-beat counter to 0.
- Reset mid-run abandons the run. No partial result is ever presented.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from the state only; none is combinational from an input.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1 with len!=0: clear out_total and out_ovf, load remaining=len, go to ACCUM.
  - On start=1 with len==0: clear out_total and out_ovf, go directly to DONE (result 0, ovf 0).
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid and in_ready are both 1. On acceptance: out_total <= out_total + zero-extended in_sum, and remaining decrements.
  - Overflow rule: if the ACC_W+1-bit sum has its carry set, out_ovf <= 1 (sticky), and out_total keeps the low ACC_W bits (wraps).
  - When the beat accepted has remaining==1, go to DONE on the next edge. in_ready drops in that same cycle, so no extra beat is taken.
  - When in_valid=0, hold all state; there is no timeout.
- DONE:
  - out_valid=1; out_total and out_ovf are held stable.
  - On out_ready=1, go to IDLE. out_valid falls on the next edge.
  - While out_ready=0, out_valid stays high indefinitely and the outputs do not change.
- start is ignored in ACCUM and DONE; it is not queued.
- start asserted in the cycle DONE->IDLE completes is ignored, because the block is not yet in IDLE. It is sampled from the following cycle onward.
- Latency: the result is visible one cycle after the last beat is accepted. Minimum run (len=1) is start, beat, then DONE, i.e. 3 cycles from start to out_valid.
- Throughput: one beat per cycle in ACCUM.
- busy = (state != IDLE).

Optional Feature:
- Macro: SUM_ACCUM_SAT_EN.
- Defined: on carry-out, out_total saturates to all ones (4095 for ACC_W=12) and stays there for the rest of the run. out_ovf is still set.
- Undefined: out_total wraps modulo 2^ACC_W as described above. out_ovf behaviour is identical in both builds.

Test Plan:
- Reset mid-run: start len=4, accept 2 beats of 7, assert rst. Required: out_total=0, out_valid=0, in_ready=0, state IDLE. Then a fresh len=1 run with beat 3 gives out_total=3.
- Basic run: start len=3, beats 0, 2, 16 (the 0+0, 1+1, 15+1 sums) back-to-back. Required: in_ready drops after the 3rd beat; out_valid=1 one cycle later; out_total=18, out_ovf=0.
- Backpressure on both sides:
  - Input stall: len=2, in_valid gaps of 5 cycles between beats of 31 and 31. Required: out_total=62.
  - Output stall: hold out_ready=0 for 10 cycles. Required: out_valid and out_total=62 stay stable, and a start pulse during the stall is ignored.
- Overflow: len=255, every beat 31. Required: total 7905 exceeds 4095, so out_ovf=1. Without the macro, out_total=7905 mod 4096=3809; with SUM_ACCUM_SAT_EN, out_total=4095.
- Zero length: start with len=0. Required: out_valid=1 on the next cycle with out_total=0, out_ovf=0, and in_ready never asserted.

Source files
------------

// File: rtl/sum_accumulator_if.sv
// -----------------------------------------------------------------------------
// sum_accumulator_if
//
// Bundles the handshake and data signals of sum_accumulator.
//   start/len            run request (driver -> block)
//   in_valid/in_sum      beat stream (driver -> block), in_ready back
//   out_valid/out_total/out_ovf  result (block -> consumer), out_ready back
//   busy                 block is inside a run (ACCUM or DONE)
//
// Modports:
//   master : the side that launches runs, supplies beats and takes results
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_total, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_total, out_ovf, busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Collects a programmed number of unsigned adder-sum beats, adds them into a
// wider running total and presents the total with a sticky overflow flag.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; abandons any run in progress
//   bus  sum_accumulator_if.slave:
//          start, len             begin a run of len beats (IDLE only)
//          in_valid, in_sum       beat input, accepted when in_ready is high
//          in_ready               high throughout ACCUM
//          out_valid              high in DONE; out_total/out_ovf held stable
//          out_ready              consumer takes the result, back to IDLE
//          out_total, out_ovf     result and sticky overflow flag
//          busy                   high in ACCUM and DONE
//
// Parameters: IN_W (beat width), ACC_W (total width, must exceed IN_W),
//             CNT_W (beat-count width). These must match the interface.
//
// Build option: define SUM_ACCUM_SAT_EN to make the total saturate at all
// ones on carry-out instead of wrapping. out_ovf behaves identically.
//
// Every output is a register, so nothing is combinational from an input.
// -----------------------------------------------------------------------------
module sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_accumulator_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [ACC_W-1:0] total_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    // Beat zero-extended to ACC_W+1 bits so the carry of the add is visible.
    logic [ACC_W:0]   beat_ext;
    logic [ACC_W:0]   sum_wide;

    assign beat_ext[IN_W-1:0] = bus.in_sum;
    generate
        for (genvar gi = IN_W; gi <= ACC_W; gi++) begin : g_zext
            assign beat_ext[gi] = 1'b0;
        end
    endgenerate

    assign sum_wide = {1'b0, total_reg} + beat_ext;

    // Next total after a beat. In saturating builds a carry pins the total
    // at all ones; further beats keep carrying (or add zero), so it stays
    // pinned for the rest of the run without an extra flag.
    logic [ACC_W-1:0] total_next;
`ifdef SUM_ACCUM_SAT_EN
    assign total_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign total_next = sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            total_reg     <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        total_reg <= '0;
                        ovf_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (bus.len != '0) begin
                            remaining_reg <= bus.len;
                            in_ready_reg  <= 1'b1;
                            state_reg     <= ACCUM;
                        end else begin
                            // Empty run: result 0 is presented immediately.
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    // in_ready_reg is high for the whole of ACCUM, so
                    // in_valid alone marks an accepted beat here.
                    if (bus.in_valid) begin
                        total_reg     <= total_next;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (sum_wide[ACC_W]) begin
                            ovf_reg <= 1'b1;
                        end
                        if (remaining_reg == CNT_W'(1)) begin
                            // Last beat: in_ready drops on this same edge,
                            // so no extra beat can be taken.
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_total = total_reg;
    assign bus.out_ovf   = ovf_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//
// Drives runs of beats into sum_accumulator and compares the presented
// result with a reference computed from the plain arithmetic sum of the
// beats (wrap modulo 2^ACC_W, or clamp when SUM_ACCUM_SAT_EN is defined).
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int IN_W  = 5;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;
    localparam int MAX_TOTAL = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int beats_q[$];

    sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference result for a run whose beats add up to 'sum'.
    function automatic int ref_total(input int sum);
`ifdef SUM_ACCUM_SAT_EN
        return (sum > MAX_TOTAL) ? MAX_TOTAL : sum;
`else
        return sum % (MAX_TOTAL + 1);
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after start was sampled.
    task automatic start_run(input int n);
        bus.start = 1'b1;
        bus.len   = CNT_W'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    task automatic send_beat(input int v, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_sum   = IN_W'(v);
        check("in_ready_accum", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
    endtask

    // Runs beats_q[0..n-1] through the block, then holds out_ready low for
    // 'stall' cycles (optionally pulsing start in the middle), then releases
    // with a start pulse coinciding with the DONE->IDLE edge.
    task automatic run_case(input int n, input int gap_max, input int stall, input bit poke);
        int sum = 0;
        int exp_tot;
        int exp_ovf;
        start_run(n);
        for (int i = 0; i < n; i++) begin
            sum += beats_q[i];
            send_beat(beats_q[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        exp_tot = ref_total(sum);
        exp_ovf = (sum > MAX_TOTAL) ? 1 : 0;
        check("out_valid_done", 32'(bus.out_valid), 32'd1);
        check("in_ready_done",  32'(bus.in_ready),  32'd0);
        check("out_total",      32'(bus.out_total), 32'(exp_tot));
        check("out_ovf",        32'(bus.out_ovf),   32'(exp_ovf));
        check("busy_done",      32'(bus.busy),      32'd1);
        for (int s = 0; s < stall; s++) begin
            if (poke && s == stall / 2) begin
                bus.start = 1'b1;
                bus.len   = CNT_W'(5);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.len   = '0;
            check("out_valid_stall", 32'(bus.out_valid), 32'd1);
            check("out_total_stall", 32'(bus.out_total), 32'(exp_tot));
            check("out_ovf_stall",   32'(bus.out_ovf),   32'(exp_ovf));
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = CNT_W'(3);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        check("out_valid_idle", 32'(bus.out_valid), 32'd0);
        check("busy_idle",      32'(bus.busy),      32'd0);
        check("in_ready_idle",  32'(bus.in_ready),  32'd0);
        $display("run len=%0d sum=%0d total=%0d ovf=%0d", n, sum, exp_tot, exp_ovf);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_total", 32'(bus.out_total), 32'd0);
        check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-run
        start_run(4);
        send_beat(7, 0);
        send_beat(7, 0);
        check("mid_total_before_rst", 32'(bus.out_total), 32'd14);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_total", 32'(bus.out_total), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset mid-run applied");
        beats_q = '{3};
        run_case(1, 0, 0, 1'b0);

        // Basic back-to-back run
        beats_q = '{0, 2, 16};
        run_case(3, 0, 1, 1'b0);

        // Input stall of 5 cycles between beats, then output stall with a
        // start pulse that must be ignored
        start_run(2);
        send_beat(31, 0);
        send_beat(31, 5);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_total",     32'(bus.out_total), 32'd62);
        beats_q = '{};
        for (int s = 0; s < 10; s++) begin
            if (s == 4) begin
                bus.start = 1'b1;
                bus.len   = CNT_W'(2);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.len   = '0;
            check("ostall_out_valid", 32'(bus.out_valid), 32'd1);
            check("ostall_total",     32'(bus.out_total), 32'd62);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("ostall_release_valid", 32'(bus.out_valid), 32'd0);
        check("ostall_release_busy",  32'(bus.busy),      32'd0);
        $display("run len=2 stalled total=62");

        // Overflow: 255 beats of 31
        beats_q = '{};
        for (int i = 0; i < 255; i++) beats_q.push_back(31);
        run_case(255, 0, 2, 1'b1);

        // Zero length
        beats_q = '{};
        run_case(0, 0, 3, 1'b1);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(1, 40));
            beats_q = '{};
            for (int i = 0; i < n; i++) beats_q.push_back(int'($urandom_range(0, 31)));
            run_case(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Long random run reaching overflow territory
        beats_q = '{};
        for (int i = 0; i < 200; i++) beats_q.push_back(int'($urandom_range(16, 31)));
        run_case(200, 1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
